// File: rtl/lbp_hcu.sv
// lbp_hcu: LBP histogram computation unit, bins one grid cell of LBP codes into a 59-bin uniform-LBP histogram.
// Ports: clk/rst (sync active-high); hcu_enable + gridX_i/gridY_i start a cell;
// lbp_addr/lbp_rdata read the LBP RAM (1-cycle latency); hist_addr/hist_wdata/hist_wen write the histogram RAM;
// gridX_o/gridY_o/hcu_finish report the completed cell.
// Optional macro HCU_BORDER_EN: skip codes of pixels on the image border.
module lbp_hcu #(
  parameter int IMG_W  = 64,
  parameter int GRID_N = 8,
  parameter int BINS   = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hcu_enable,
  input  logic [3:0]  gridX_i,
  input  logic [3:0]  gridY_i,
  output logic [11:0] lbp_addr,
  input  logic [7:0]  lbp_rdata,
  output logic [11:0] hist_addr,
  output logic [6:0]  hist_wdata,
  output logic        hist_wen,
  output logic [3:0]  gridX_o,
  output logic [3:0]  gridY_o,
  output logic        hcu_finish
);
  localparam int CELL = IMG_W / GRID_N;
  localparam int NPIX = CELL * CELL;
  typedef logic [255:0][5:0] lut_t;
  // Uniform codes take consecutive bins in ascending code order; everything else lands in the last bin.
  function automatic lut_t build_lut();
    lut_t l;
    logic [7:0] v, x;
    int n, k;
    k = 0;
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      x = v ^ {v[0], v[7:1]};
      n = 0;
      for (int j = 0; j < 8; j++) n += int'(x[j]);
      l[8'(i)] = (n <= 2) ? 6'(k) : 6'(BINS - 1);
      k += (n <= 2) ? 1 : 0;
    end
    return l;
  endfunction
  localparam lut_t LUT = build_lut();
  typedef enum logic [2:0] {IDLE, CLEAR, READ, DRAIN, WRITE, DONE} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_gx, r_gy, r_gx_o, r_gy_o;
  logic [6:0]  r_cnt;
  logic [11:0] r_lbp_addr, r_hist_addr;
  logic [11:0] w_row, w_col, w_lbp_addr, w_hist_addr;
  logic        r_vld, r_brd, w_brd;
  logic [5:0]  w_bin;
  logic [6:0]  r_bin [BINS];
  assign w_row       = 12'(int'(r_gy) * CELL + int'(r_cnt) / CELL);
  assign w_col       = 12'(int'(r_gx) * CELL + int'(r_cnt) % CELL);
  assign w_lbp_addr  = 12'(int'(w_row) * IMG_W + int'(w_col));
  assign w_hist_addr = 12'((int'(r_gy) * GRID_N + int'(r_gx)) * BINS + int'(r_cnt));
  assign w_bin       = LUT[lbp_rdata];
`ifdef HCU_BORDER_EN
  assign w_brd = (w_row == '0) || (w_row == 12'(IMG_W - 1)) || (w_col == '0) || (w_col == 12'(IMG_W - 1));
`else
  assign w_brd = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (hcu_enable) w_next = (gridX_i >= 4'(GRID_N) || gridY_i >= 4'(GRID_N)) ? DONE : CLEAR;
      CLEAR:   w_next = READ;
      READ:    w_next = (r_cnt == 7'(NPIX - 1)) ? DRAIN : READ;
      DRAIN:   w_next = WRITE;
      WRITE:   w_next = (r_cnt == 7'(BINS - 1)) ? DONE : WRITE;
      default: w_next = IDLE;
    endcase
  end
  assign hist_wen   = r_state == WRITE;
  assign hcu_finish = r_state == DONE;
  assign lbp_addr   = (r_state == READ) ? w_lbp_addr : r_lbp_addr;
  assign hist_addr  = hist_wen ? w_hist_addr : r_hist_addr;
  assign hist_wdata = hist_wen ? r_bin[r_cnt[5:0]] : '0;
  assign gridX_o    = hcu_finish ? r_gx : r_gx_o;
  assign gridY_o    = hcu_finish ? r_gy : r_gy_o;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gx        <= '0;
      r_gy        <= '0;
      r_gx_o      <= '0;
      r_gy_o      <= '0;
      r_cnt       <= '0;
      r_vld       <= 1'b0;
      r_brd       <= 1'b0;
      r_lbp_addr  <= '0;
      r_hist_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && hcu_enable) begin
        r_gx <= gridX_i;
        r_gy <= gridY_i;
      end
      r_cnt <= ((r_state == READ && w_next == READ) || (r_state == WRITE && w_next == WRITE)) ? r_cnt + 7'd1 : '0;
      // Read data returns one cycle after its address, so qualifiers are delayed to match.
      r_vld <= r_state == READ;
      r_brd <= w_brd;
      if (r_state == READ) r_lbp_addr <= w_lbp_addr;
      if (hist_wen) r_hist_addr <= w_hist_addr;
      if (hcu_finish) begin
        r_gx_o <= r_gx;
        r_gy_o <= r_gy;
      end
    end
  end
  always_ff @(posedge clk)
    for (int b = 0; b < BINS; b++)
      if (rst || r_state == CLEAR) r_bin[b] <= '0;
      else if (r_vld && !r_brd && w_bin == 6'(b)) r_bin[b] <= r_bin[b] + 7'd1;
endmodule
